// File: rtl/sram_march_bist_if.sv
// Memory port between the march BIST initiator and the SRAM wrapper:
// request/grant address phase plus rvalid/rready response phase with complement parity.
interface sram_march_bist_if #(
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 10
);
    logic                    req_o;
    logic                    we_o;
    logic                    rready_o;
    logic [AW-1:0]           addr_o;
    logic [DATA_WIDTH-1:0]   wdata_o;
    logic [DATA_WIDTH/8-1:0] be_o;
    logic [DATA_WIDTH-1:0]   rdata_i;
    logic                    gnt_i;
    logic                    gntpar_i;
    logic                    rvalid_i;
    logic                    rvalidpar_i;

    modport master (
        output req_o, we_o, rready_o, addr_o, wdata_o, be_o,
        input  rdata_i, gnt_i, gntpar_i, rvalid_i, rvalidpar_i
    );

    modport slave (
        input  req_o, we_o, rready_o, addr_o, wdata_o, be_o,
        output rdata_i, gnt_i, gntpar_i, rvalid_i, rvalidpar_i
    );
endinterface

// File: rtl/sram_march_bist.sv
// Four-phase march BIST initiator: W(Z) up, R(Z)W(O) up, R(O)W(Z) down, R(Z) up,
// one outstanding transaction, with parity, timeout and first-failure capture.
module sram_march_bist #(
    parameter int  DATA_WIDTH     = 32,
    parameter int  NUM_WORDS      = 1024,
    parameter int  TIMEOUT_CYCLES = 16,
    localparam int AW             = $clog2(NUM_WORDS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             fail_o,
    output logic             perr_o,
    output logic             timeout_o,
    output logic [AW-1:0]    fail_addr_o,
    output logic [1:0]       fail_phase_o,
    sram_march_bist_if.master mem
);
    localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW-1:0] LAST    = AW'(NUM_WORDS - 1);
    localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, TOUT, DONE} state_t;

    state_t                state, state_n;
    logic [1:0]            phase, phase_n;
    logic                  rd, rd_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic                  busy_n, done_n, fail_n, perr_n, tout_n;
    logic [AW-1:0]         fail_addr_n;
    logic [1:0]            fail_phase_n;
    logic                  req, req_n, we, we_n, rready, rready_n;
    logic [AW-1:0]         addr, addr_n;
    logic [DATA_WIDTH-1:0] wdata, wdata_n;
    logic                  perr_evt, tout_evt, miss_evt, finish, last_op;
    logic [1:0]            nx_phase;
    logic                  nx_rd;
    logic [AW-1:0]         nx_addr;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic ones);
        return ones ? '1 : '0;
    endfunction

    assign mem.req_o    = req;
    assign mem.we_o     = we;
    assign mem.rready_o = rready;
    assign mem.addr_o   = addr;
    assign mem.wdata_o  = wdata;
    assign mem.be_o     = '1;

    // Successor of the current march element; P2 enters at the top address and walks down.
    always_comb begin
        nx_phase = phase;
        nx_rd    = rd;
        nx_addr  = addr;
        last_op  = 1'b0;
        case (phase)
            2'd0: begin
                if (addr == LAST) begin
                    nx_phase = 2'd1;
                    nx_addr  = '0;
                    nx_rd    = 1'b1;
                end else begin
                    nx_addr = addr + AW'(1);
                end
            end
            2'd1: begin
                if (rd) begin
                    nx_rd = 1'b0;
                end else begin
                    nx_rd = 1'b1;
                    if (addr == LAST) nx_phase = 2'd2;
                    else              nx_addr  = addr + AW'(1);
                end
            end
            2'd2: begin
                if (rd) begin
                    nx_rd = 1'b0;
                end else begin
                    nx_rd = 1'b1;
                    if (addr == '0) nx_phase = 2'd3;
                    else            nx_addr  = addr - AW'(1);
                end
            end
            default: begin
                if (addr == LAST) last_op = 1'b1;
                else              nx_addr = addr + AW'(1);
            end
        endcase
    end

    always_comb begin
        state_n      = state;
        phase_n      = phase;
        rd_n         = rd;
        cnt_n        = cnt;
        busy_n       = busy_o;
        done_n       = done_o;
        fail_n       = fail_o;
        perr_n       = perr_o;
        tout_n       = timeout_o;
        fail_addr_n  = fail_addr_o;
        fail_phase_n = fail_phase_o;
        req_n        = req;
        we_n         = we;
        rready_n     = rready;
        addr_n       = addr;
        wdata_n      = wdata;
        tout_evt     = 1'b0;
        miss_evt     = 1'b0;
        finish       = 1'b0;
        perr_evt     = busy_o && ((mem.gntpar_i == mem.gnt_i) ||
                                  (mem.rvalidpar_i == mem.rvalid_i) ||
                                  (mem.rvalid_i && state != WAIT));
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_n      = REQ;
                    busy_n       = 1'b1;
                    done_n       = 1'b0;
                    fail_n       = 1'b0;
                    perr_n       = 1'b0;
                    tout_n       = 1'b0;
                    fail_addr_n  = '0;
                    fail_phase_n = '0;
                    phase_n      = 2'd0;
                    rd_n         = 1'b0;
                    addr_n       = '0;
                    we_n         = 1'b1;
                    wdata_n      = pattern(1'b0);
                    req_n        = 1'b1;
                    cnt_n        = '0;
                end
            end
            REQ: begin
                if (mem.gnt_i && !perr_evt) begin
                    state_n  = WAIT;
                    req_n    = 1'b0;
                    rready_n = 1'b1;
                    cnt_n    = '0;
                end else begin
                    cnt_n    = cnt + CW'(1);
                    tout_evt = (cnt == CNT_LIM);
                end
            end
            WAIT: begin
                miss_evt = mem.rvalid_i && rready && rd &&
                           (mem.rdata_i != pattern(phase == 2'd2));
                if (mem.rvalid_i && !perr_evt) begin
                    cnt_n = '0;
                    if (last_op) begin
                        finish = 1'b1;
                    end else begin
                        state_n  = REQ;
                        rready_n = 1'b0;
                        req_n    = 1'b1;
                        phase_n  = nx_phase;
                        rd_n     = nx_rd;
                        addr_n   = nx_addr;
                        we_n     = !nx_rd;
                        wdata_n  = pattern(nx_phase == 2'd1);
                    end
                end else begin
                    cnt_n    = cnt + CW'(1);
                    tout_evt = (cnt == CNT_LIM);
                end
            end
            TOUT:    finish  = 1'b1;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // Every raised flag is recorded; parity and mismatch abort straight to DONE,
        // a lone timeout spends one cycle in TOUT so the flag leads done_o.
        if (perr_evt) perr_n = 1'b1;
        if (tout_evt) tout_n = 1'b1;
        if (miss_evt) begin
            fail_n       = 1'b1;
            fail_addr_n  = addr;
            fail_phase_n = phase;
        end
        if (perr_evt || miss_evt || finish) begin
            state_n  = DONE;
            busy_n   = 1'b0;
            done_n   = 1'b1;
            req_n    = 1'b0;
            rready_n = 1'b0;
            cnt_n    = '0;
        end else if (tout_evt) begin
            state_n  = TOUT;
            req_n    = 1'b0;
            rready_n = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            phase        <= 2'd0;
            rd           <= 1'b0;
            cnt          <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            fail_o       <= 1'b0;
            perr_o       <= 1'b0;
            timeout_o    <= 1'b0;
            fail_addr_o  <= '0;
            fail_phase_o <= '0;
            req          <= 1'b0;
            we           <= 1'b0;
            rready       <= 1'b0;
            addr         <= '0;
            wdata        <= '0;
        end else begin
            state        <= state_n;
            phase        <= phase_n;
            rd           <= rd_n;
            cnt          <= cnt_n;
            busy_o       <= busy_n;
            done_o       <= done_n;
            fail_o       <= fail_n;
            perr_o       <= perr_n;
            timeout_o    <= tout_n;
            fail_addr_o  <= fail_addr_n;
            fail_phase_o <= fail_phase_n;
            req          <= req_n;
            we           <= we_n;
            rready       <= rready_n;
            addr         <= addr_n;
            wdata        <= wdata_n;
        end
    end
endmodule

// File: doc/sram_march_bist.md
# sram_march_bist

Built-in self-test initiator for the single-port SRAM wrapper's req/gnt/rvalid/rready port. On `start_i` it takes over the memory port and runs a fixed four-phase march test over every word. It checks read data and the complemented handshake parity lines, then reports pass/fail, the first failing address and phase, parity errors and handshake timeouts. It sits between the SoC-side memory mux and the SRAM instance and drives the SRAM while `busy_o` is high.

## Interface
- `DATA_WIDTH`, 32: word width; must be a multiple of 8.
- `NUM_WORDS`, 1024: words tested, any value ≥ 2; `AW = $clog2(NUM_WORDS)`.
- `TIMEOUT_CYCLES`, 16: maximum cycles waited for `gnt_i` or `rvalid_i` before abort.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  start request; sampled only in IDLE.
- `busy_o`  out  1  test running.
- `done_o`  out  1  test finished; level, held until the next accepted start.
- `fail_o`  out  1  data mismatch detected.
- `perr_o`  out  1  parity or protocol error detected.
- `timeout_o`  out  1  handshake timeout.
- `fail_addr_o`  out  AW  address of the first mismatch.
- `fail_phase_o`  out  2  phase of the first mismatch.
- `req_o`, `we_o`, `rready_o`  out  1 each  memory request, write enable, read ready.
- `addr_o`  out  AW  memory address.
- `wdata_o`  out  DATA_WIDTH  write data.
- `be_o`  out  DATA_WIDTH/8  byte enables; constant all-ones.
- `rdata_i`  in  DATA_WIDTH  read data.
- `gnt_i`, `gntpar_i`, `rvalid_i`, `rvalidpar_i`  in  1 each  grant, response valid and their complement parity.

## Operation
- Reset values:
  - `req_o`, `we_o`, `rready_o`, `busy_o`, `done_o`, `fail_o`, `perr_o` and `timeout_o` are 0.
  - `addr_o`, `wdata_o`, `fail_addr_o` and `fail_phase_o` are 0.
  - `be_o` is all-ones.
- Phases (Z is all-zeros, O is all-ones):
  - P0: ascending, W(Z).
  - P1: ascending, R(Z) then W(O).
  - P2: descending from NUM_WORDS-1 to 0, R(O) then W(Z).
  - P3: ascending, R(Z).
- Ascending phases end at NUM_WORDS-1 and descending phases end at 0. Addresses never wrap.
- States:
  - IDLE: on `start_i`, clear all result flags, clear `done_o`, set `busy_o`, go to REQ.
  - REQ: `req_o`=1 with the `addr_o`/`we_o`/`wdata_o` of the current operation. On `gnt_i`=1 the request is accepted; go to WAIT.
  - WAIT: `rready_o`=1, `req_o`=0. On `rvalid_i`=1 the response is consumed; then either advance to the next operation (go to REQ) or, after the last P3 read, go to DONE.
  - DONE: `busy_o`=0, `done_o`=1, go to IDLE (`done_o` stays high).
- Exactly one transaction is outstanding at a time.
- Writes also wait for and consume `rvalid_i`; their `rdata_i` is ignored.
- Data compare happens only on read responses: `rdata_i` is compared with the expected pattern in the cycle with `rvalid_i & rready_o`.
- On the first mismatch:
  - set `fail_o` and capture `fail_addr_o` and `fail_phase_o`;
  - abort to DONE;
  - the captured values hold until the next start.
- Parity is checked every cycle while busy. The following set sticky `perr_o` and abort:
  - `gntpar_i != ~gnt_i`;
  - `rvalidpar_i != ~rvalid_i`;
  - `rvalid_i`=1 in any state other than WAIT.
- A wait counter runs while in REQ or WAIT. It is cleared on each state change. When it reaches TIMEOUT_CYCLES, set `timeout_o` and abort.
- Abort priority when events coincide in one cycle: parity, then timeout, then data mismatch. All raised flags are still recorded.
- `start_i` is ignored while `busy_o`=1.
- Reset mid-run: all outputs return to their reset values immediately. `req_o` drops asynchronously.

## Timing
- Latency from start to first request: start accepted in cycle 0, `req_o` high in cycle 1.
- With a zero-wait-state responder:
  - every transaction takes exactly 2 cycles (REQ, then WAIT);
  - back-to-back transactions carry no idle cycle;
  - a run has 6·NUM_WORDS transactions and takes 12·NUM_WORDS cycles.
- `done_o` rises the cycle after the final response. `busy_o` falls in that same cycle.
- `addr_o`, `we_o` and `wdata_o` are registered outputs. They are stable for the whole time `req_o` is high.

## Test plan
- Clean run: NUM_WORDS=16, DATA_WIDTH=32, fault-free SRAM model, start in cycle 0 → 96 requests; `done_o`=1 in cycle 193; `fail_o`=`perr_o`=`timeout_o`=0; final memory contents all 0.
- Stuck-at-0 on bit 3 of word 5 → `fail_o`=1, `fail_addr_o`=5, `fail_phase_o`=2; no requests after the aborted read.
- Stuck-at-1 on bit 0 of word 9 → `fail_o`=1, `fail_addr_o`=9, `fail_phase_o`=1.
- Hold `gnt_i`=0 (with `gntpar_i`=1) after start → `timeout_o`=1 exactly 16 cycles after `req_o` rises; `done_o`=1 in the following cycle.
- Force `gntpar_i`=`gnt_i` for 1 cycle mid-P1 → `perr_o`=1, abort, `done_o`=1; a new start clears all flags and the rerun passes.
- Reset during P2 → all outputs at reset values in the same cycle; a later start runs a clean full test.
